// File: rtl/scr_pkg.sv
// Shared geometry, FSM state type and logical-to-physical row mapping for the screen buffer.
package scr_pkg;

  localparam int unsigned Cols  = 70;
  localparam int unsigned Rows  = 30;
  localparam int unsigned Word  = 8;
  localparam int unsigned ColAw = 7;
  localparam int unsigned RowAw = 5;
  localparam logic [Word-1:0] Fill = 8'h00;

  // Rows at one bit wider than a row address, so the wrap compare needs no resizing.
  localparam logic [RowAw:0] RowsWide = (RowAw + 1)'(Rows);

  typedef enum logic [1:0] {
    StIdle,
    StClrAll,
    StClrRow
  } scr_state_e;

  // lrow + base is always < 2*Rows, so one conditional subtract replaces a modulo.
  function automatic logic [RowAw-1:0] map_row(input logic [RowAw-1:0] lrow,
                                               input logic [RowAw-1:0] base);
    logic [RowAw:0] sum;
    sum = {1'b0, lrow} + {1'b0, base};
    if (sum >= RowsWide) begin
      sum = sum - RowsWide;
    end
    return sum[RowAw-1:0];
  endfunction

endpackage

// File: rtl/scr_mem_2p.sv
// Simple dual-port synchronous RAM: one write port, one registered read port (read-before-write).
module scr_mem_2p #(
  parameter int unsigned Depth = 3840,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write and read in one process so a same-address read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scr_text_buf.sv
// Character screen buffer: user writes, VGA reads, hardware clear and scroll via a circular row base.
module scr_text_buf
  import scr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [RowAw-1:0] wr_row,
  input  logic [ColAw-1:0] wr_col,
  input  logic [Word-1:0]  wr_data,
  input  logic [RowAw-1:0] rd_row,
  input  logic [ColAw-1:0] rd_col,
  output logic [Word-1:0]  rd_data,
  input  logic             clr_req,
  input  logic             scroll_req,
  output logic             busy
);

  localparam int unsigned Depth = Rows << ColAw;
  localparam int unsigned AddrW = RowAw + ColAw;
  localparam logic [RowAw-1:0] RowsN   = RowAw'(Rows);
  localparam logic [ColAw-1:0] ColsN   = ColAw'(Cols);
  localparam logic [RowAw-1:0] LastRow = RowAw'(Rows - 1);
  localparam logic [ColAw-1:0] LastCol = ColAw'(Cols - 1);

  scr_state_e       state_q, state_d;
  logic [RowAw-1:0] base_q, base_d;
  logic [RowAw-1:0] ptr_row_q, ptr_row_d;
  logic [ColAw-1:0] ptr_col_q, ptr_col_d;
  logic             busy_q;
  logic             rd_ok_q;

  logic             wr_ok, rd_ok;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr, mem_raddr;
  logic [Word-1:0]  mem_wdata, mem_rdata;

  assign wr_ok = wr_en && (wr_row < RowsN) && (wr_col < ColsN);
  assign rd_ok = (rd_row < RowsN) && (rd_col < ColsN);
  // Out-of-range reads still need a legal RAM address; the result is masked to Fill anyway.
  assign mem_raddr = rd_ok ? {map_row(rd_row, base_q), rd_col} : '0;

  // State register plus clear pointer, row base, busy flag and read-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClrAll;
      base_q    <= '0;
      ptr_row_q <= '0;
      ptr_col_q <= '0;
      busy_q    <= 1'b1;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ptr_row_q <= ptr_row_d;
      ptr_col_q <= ptr_col_d;
      busy_q    <= (state_d != StIdle);
      rd_ok_q   <= rd_ok;
    end
  end

  // Next-state logic: request arbitration in idle, pointer walk during clears.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    ptr_row_d = ptr_row_q;
    ptr_col_d = ptr_col_q;
    case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d   = StClrAll;
          base_d    = '0;
          ptr_row_d = '0;
          ptr_col_d = '0;
        end else if (scroll_req) begin
          // Old logical top row becomes the new (blank) bottom row.
          state_d   = StClrRow;
          ptr_row_d = base_q;
          ptr_col_d = '0;
          base_d    = (base_q == LastRow) ? '0 : base_q + 1'b1;
        end
      end
      StClrAll: begin
        if (ptr_col_q == LastCol) begin
          ptr_col_d = '0;
          if (ptr_row_q == LastRow) begin
            ptr_row_d = '0;
            state_d   = StIdle;
          end else begin
            ptr_row_d = ptr_row_q + 1'b1;
          end
        end else begin
          ptr_col_d = ptr_col_q + 1'b1;
        end
      end
      StClrRow: begin
        if (ptr_col_q == LastCol) begin
          ptr_col_d = '0;
          state_d   = StIdle;
        end else begin
          ptr_col_d = ptr_col_q + 1'b1;
        end
      end
      default: state_d = StClrAll;
    endcase
  end

  // Write-port mux: clear pointer owns the port whenever an operation is running.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {ptr_row_q, ptr_col_q};
    mem_wdata = Fill;
    if (state_q != StIdle) begin
      mem_we = 1'b1;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = {map_row(wr_row, base_q), wr_col};
      mem_wdata = wr_data;
    end
  end

  scr_mem_2p #(
    .Depth (Depth),
    .Width (Word),
    .AddrW (AddrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign rd_data = rd_ok_q ? mem_rdata : Fill;
  assign busy    = busy_q;

endmodule

// File: tb/tb_scr_text_buf.sv
// Directed self-checking bench for scr_text_buf.
module tb_scr_text_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_row = '0;
  logic [6:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] rd_row = '0;
  logic [6:0] rd_col = '0;
  logic [7:0] rd_data;
  logic       clr_req = 1'b0;
  logic       scroll_req = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scr_text_buf dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .clr_req    (clr_req),
    .scroll_req (scroll_req),
    .busy       (busy)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d);
    wr_row  = 5'(r);
    wr_col  = 7'(c);
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] d);
    rd_row = 5'(r);
    rd_col = 7'(c);
    step();
    d = rd_data;
  endtask

  task automatic read_all(input logic [7:0] val, output int nonfill, output int hits);
    logic [7:0] d;
    nonfill = 0;
    hits    = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 70; c++) begin
        rd(r, c, d);
        if (d !== 8'h00) nonfill++;
        if (d === val) hits++;
      end
    end
  endtask

  task automatic pulse_scroll();
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
  endtask

  task automatic test_reset();
    int n, nf, h;
    logic [7:0] d;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h want 00", rd_data);
    end
    wait_idle(n);
    n_checks++;
    if (n != 2100) begin
      n_fail++;
      $display("FAIL reset_clear_len: got %0d want 2100", n);
    end
    rd(5, 3, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_read_5_3: got %h want 00", d);
    end
    read_all(8'h00, nf, h);
    n_checks++;
    if (nf != 0) begin
      n_fail++;
      $display("FAIL reset_all_fill: got %0d non-fill cells want 0", nf);
    end
  endtask

  task automatic test_write();
    logic [7:0] d;
    wr(0, 0, 8'h41);
    wr(29, 69, 8'h5A);
    rd(0, 0, d);
    n_checks++;
    if (d !== 8'h41) begin
      n_fail++;
      $display("FAIL wr_0_0: got %h want 41", d);
    end
    rd(29, 69, d);
    n_checks++;
    if (d !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_29_69: got %h want 5a", d);
    end
    wr(30, 0, 8'h11);
    wr(0, 70, 8'h22);
    rd(30, 0, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_oob_row: got %h want 00", d);
    end
    rd(0, 70, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_oob_col: got %h want 00", d);
    end
    n_checks++;
    if (dut.u_mem.mem_q[70] === 8'h22) begin
      n_fail++;
      $display("FAIL wr_oob_col_dropped: got %h in phys (0,70) want not 22",
               dut.u_mem.mem_q[70]);
    end
    rd(0, 0, d);
    n_checks++;
    if (d !== 8'h41) begin
      n_fail++;
      $display("FAIL wr_oob_no_alias: got %h want 41", d);
    end
    // Same-cycle read and write of (3,3).
    rd_row  = 5'd3;
    rd_col  = 7'd3;
    wr_row  = 5'd3;
    wr_col  = 7'd3;
    wr_data = 8'h66;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rbw_old: got %h want 00", rd_data);
    end
    step();
    n_checks++;
    if (rd_data !== 8'h66) begin
      n_fail++;
      $display("FAIL rbw_new: got %h want 66", rd_data);
    end
  endtask

  task automatic test_scroll();
    int n, nf, h;
    logic [7:0] d;
    wr(1, 0, 8'h42);
    wr(0, 0, 8'h41);
    pulse_scroll();
    wait_idle(n);
    n_checks++;
    if (n != 70) begin
      n_fail++;
      $display("FAIL scroll_len: got %0d want 70", n);
    end
    rd(0, 0, d);
    n_checks++;
    if (d !== 8'h42) begin
      n_fail++;
      $display("FAIL scroll_top: got %h want 42", d);
    end
    rd(29, 0, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL scroll_bottom: got %h want 00", d);
    end
    read_all(8'h41, nf, h);
    n_checks++;
    if (h != 0) begin
      n_fail++;
      $display("FAIL scroll_41_gone: got %0d cells of 41 want 0", h);
    end
  endtask

  task automatic test_wrap();
    int n, bad;
    logic [7:0] d;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_idle(n);
    n_checks++;
    if (n != 2100) begin
      n_fail++;
      $display("FAIL wrap_clear_len: got %0d want 2100", n);
    end
    wr(29, 0, 8'h43);
    bad = 0;
    for (int i = 0; i < 29; i++) begin
      pulse_scroll();
      wait_idle(n);
      if (n != 70) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_scroll_lens: got %0d wrong durations want 0", bad);
    end
    rd(0, 0, d);
    n_checks++;
    if (d !== 8'h43) begin
      n_fail++;
      $display("FAIL wrap_29: got %h want 43", d);
    end
    pulse_scroll();
    wait_idle(n);
    rd(0, 0, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_30: got %h want 00", d);
    end
    wr(0, 0, 8'h44);
    n_checks++;
    if (dut.u_mem.mem_q[0] !== 8'h44) begin
      n_fail++;
      $display("FAIL wrap_base0: got %h at phys (0,0) want 44", dut.u_mem.mem_q[0]);
    end
  endtask

  task automatic test_contention();
    int n;
    logic [7:0] d;
    pulse_scroll();
    wait_idle(n);
    // Base is now 1; a simultaneous clear must win and reset it.
    clr_req    = 1'b1;
    scroll_req = 1'b1;
    step();
    clr_req    = 1'b0;
    scroll_req = 1'b0;
    wr_row  = 5'd2;
    wr_col  = 7'd2;
    wr_data = 8'h55;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    wait_idle(n);
    n = n + 1;
    n_checks++;
    if (n != 2100) begin
      n_fail++;
      $display("FAIL clr_wins_len: got %0d want 2100", n);
    end
    rd(2, 2, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL busy_write_dropped: got %h want 00", d);
    end
    wr(0, 0, 8'h77);
    n_checks++;
    if (dut.u_mem.mem_q[0] !== 8'h77) begin
      n_fail++;
      $display("FAIL clr_wins_base0: got %h at phys (0,0) want 77", dut.u_mem.mem_q[0]);
    end
    pulse_scroll();
    for (int i = 0; i < 5; i++) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_idle(n);
    n = n + 6;
    n_checks++;
    if (n != 70) begin
      n_fail++;
      $display("FAIL clr_ignored_len: got %0d want 70", n);
    end
  endtask

  task automatic test_reset_mid();
    int n, nf, h;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_idle(n);
    wr(5, 5, 8'h99);
    wr(17, 40, 8'hA5);
    wr(29, 69, 8'h3C);
    pulse_scroll();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: got %b want 1", busy);
    end
    wait_idle(n);
    n_checks++;
    if (n != 2100) begin
      n_fail++;
      $display("FAIL midrst_clear_len: got %0d want 2100", n);
    end
    read_all(8'h00, nf, h);
    n_checks++;
    if (nf != 0) begin
      n_fail++;
      $display("FAIL midrst_all_fill: got %0d non-fill cells want 0", nf);
    end
    wr(0, 0, 8'h88);
    n_checks++;
    if (dut.u_mem.mem_q[0] !== 8'h88) begin
      n_fail++;
      $display("FAIL midrst_base0: got %h at phys (0,0) want 88", dut.u_mem.mem_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_scroll();
    test_wrap();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
